// File: rtl/glyph_sprite_rom.sv
`default_nettype none
// ============================================================================
// Module   : glyph_sprite_rom
// Brief    : Digit glyph ROM (1 bpp) rendered as a scaled sprite with a fixed
//            2-cycle pixel pipeline; optional blinking under SPRITE_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module glyph_sprite_rom #(
    parameter int                 GLYPH_W      = 8,
    parameter int                 GLYPH_H      = 16,
    parameter int                 NUM_GLYPHS   = 10,
    parameter int                 COLOR_W      = 6,
    parameter int                 X_W          = 10,
    parameter int                 Y_W          = 10,
    parameter logic [COLOR_W-1:0] FG_COLOR     = 6'b000000,
    parameter logic [COLOR_W-1:0] BG_COLOR     = 6'b111111,
    parameter int                 BLINK_FRAMES = 30
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          frame_start,
    input  logic                          cfg_wr,
    input  logic [$clog2(NUM_GLYPHS)-1:0] cfg_glyph,
    input  logic [X_W-1:0]                cfg_org_x,
    input  logic [Y_W-1:0]                cfg_org_y,
    input  logic [1:0]                    cfg_scale,
    input  logic                          blink_on,
    input  logic [X_W-1:0]                pix_x,
    input  logic [Y_W-1:0]                pix_y,
    input  logic                          pix_valid,
    output logic [COLOR_W-1:0]            pix_color,
    output logic                          pix_hit,
    output logic                          pix_out_valid
);

    localparam int c_GI_W  = $clog2(NUM_GLYPHS);
    localparam int c_COL_W = $clog2(GLYPH_W);
    localparam int c_ROW_W = $clog2(GLYPH_H);

    // Digits are drawn from seven-segment style strokes {a,b,c,d,e,f,g}:
    // a row 1, f/b rows 2-7, g row 7, e/c rows 8-13, d row 14; col 0 stays clear.
    function automatic logic [7:0] glyph_row(input logic [c_GI_W-1:0] g,
                                             input logic [c_ROW_W-1:0] r);
        logic [6:0]  seg;
        int unsigned ri;
        logic [7:0]  bits;
        case (32'(g))
            0:       seg = 7'b1111110;
            1:       seg = 7'b0110000;
            2:       seg = 7'b1101101;
            3:       seg = 7'b1111001;
            4:       seg = 7'b0110011;
            5:       seg = 7'b1011011;
            6:       seg = 7'b1011111;
            7:       seg = 7'b1110000;
            8:       seg = 7'b1111111;
            9:       seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        ri   = 32'(r);
        bits = 8'h00;
        if (ri == 1 && seg[6])
            bits = 8'h1C;
        if (ri >= 2 && ri <= 7)
            bits = (seg[1] ? 8'h02 : 8'h00) | (seg[5] ? 8'h20 : 8'h00);
        if (ri == 7 && seg[0])
            bits = bits | 8'h1C;
        if (ri >= 8 && ri <= 13)
            bits = (seg[2] ? 8'h02 : 8'h00) | (seg[4] ? 8'h20 : 8'h00);
        if (ri == 14 && seg[3])
            bits = 8'h1C;
        return bits;
    endfunction

    logic [c_GI_W-1:0]  r_sh_glyph,  r_act_glyph;
    logic [X_W-1:0]     r_sh_org_x,  r_act_org_x;
    logic [Y_W-1:0]     r_sh_org_y,  r_act_org_y;
    logic [1:0]         r_sh_scale,  r_act_scale;
    logic               w_cfg_ok;
    logic               w_visible;

    assign w_cfg_ok = cfg_wr && (32'(cfg_glyph) < NUM_GLYPHS);

    // A write coinciding with frame_start bypasses the shadow straight to active.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sh_glyph  <= '0;
            r_sh_org_x  <= '0;
            r_sh_org_y  <= '0;
            r_sh_scale  <= '0;
            r_act_glyph <= '0;
            r_act_org_x <= '0;
            r_act_org_y <= '0;
            r_act_scale <= '0;
        end else begin
            if (w_cfg_ok) begin
                r_sh_glyph <= cfg_glyph;
                r_sh_org_x <= cfg_org_x;
                r_sh_org_y <= cfg_org_y;
                r_sh_scale <= cfg_scale;
            end
            if (frame_start) begin
                r_act_glyph <= w_cfg_ok ? cfg_glyph : r_sh_glyph;
                r_act_org_x <= w_cfg_ok ? cfg_org_x : r_sh_org_x;
                r_act_org_y <= w_cfg_ok ? cfg_org_y : r_sh_org_y;
                r_act_scale <= w_cfg_ok ? cfg_scale : r_sh_scale;
            end
        end
    end

`ifdef SPRITE_BLINK_EN
    localparam int c_BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [c_BLK_W-1:0] r_blk_cnt;
    logic               r_visible;

    always_ff @(posedge clk) begin
        if (!reset_n || !blink_on) begin
            r_blk_cnt <= '0;
            r_visible <= 1'b1;
        end else if (frame_start) begin
            if (r_blk_cnt == c_BLK_W'(BLINK_FRAMES - 1)) begin
                r_blk_cnt <= '0;
                r_visible <= ~r_visible;
            end else begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

    assign w_visible = r_visible;
`else
    logic w_unused_blink;
    assign w_unused_blink = blink_on;
    assign w_visible      = 1'b1;
`endif

    // Stage 1: signed offsets keep pixels left/above the origin from wrapping.
    logic [X_W:0]       w_dx, w_wlim;
    logic [Y_W:0]       w_dy, w_hlim;
    logic               w_inside;
    logic [c_COL_W-1:0] w_col;
    logic [c_ROW_W-1:0] w_row;

    assign w_dx     = {1'b0, pix_x} - {1'b0, r_act_org_x};
    assign w_dy     = {1'b0, pix_y} - {1'b0, r_act_org_y};
    assign w_wlim   = (X_W+1)'(GLYPH_W) << r_act_scale;
    assign w_hlim   = (Y_W+1)'(GLYPH_H) << r_act_scale;
    assign w_inside = pix_valid && !w_dx[X_W] && (w_dx < w_wlim)
                                && !w_dy[Y_W] && (w_dy < w_hlim);
    assign w_col    = c_COL_W'(w_dx >> r_act_scale);
    assign w_row    = c_ROW_W'(w_dy >> r_act_scale);

    logic               r_s1_valid, r_s1_inside, r_s1_vis;
    logic [c_COL_W-1:0] r_s1_col;
    logic [c_ROW_W-1:0] r_s1_row;
    logic [c_GI_W-1:0]  r_s1_glyph;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_inside <= 1'b0;
            r_s1_vis    <= 1'b1;
            r_s1_col    <= '0;
            r_s1_row    <= '0;
            r_s1_glyph  <= '0;
        end else begin
            r_s1_valid  <= pix_valid;
            r_s1_inside <= w_inside;
            r_s1_vis    <= w_visible;
            r_s1_col    <= w_col;
            r_s1_row    <= w_row;
            r_s1_glyph  <= r_act_glyph;
        end
    end

    // Stage 2: ROM lookup and colour select.
    logic [7:0]         w_rowbits;
    logic               w_hit;
    logic               r_hit, r_ovalid;
    logic [COLOR_W-1:0] r_color;

    assign w_rowbits = glyph_row(r_s1_glyph, r_s1_row);
    assign w_hit     = r_s1_inside && w_rowbits[r_s1_col] && r_s1_vis;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hit    <= 1'b0;
            r_ovalid <= 1'b0;
            r_color  <= BG_COLOR;
        end else begin
            r_hit    <= w_hit;
            r_ovalid <= r_s1_valid;
            r_color  <= w_hit ? FG_COLOR : BG_COLOR;
        end
    end

    assign pix_hit       = r_hit;
    assign pix_out_valid = r_ovalid;
    assign pix_color     = r_color;

endmodule
`default_nettype wire

// File: tb/tb_glyph_sprite_rom.sv
`default_nettype none
// ============================================================================
// Module   : tb_glyph_sprite_rom
// Brief    : Directed self-checking bench for glyph_sprite_rom.
// Revision : 1.0 - initial release
// ============================================================================
module tb_glyph_sprite_rom;

`ifdef SPRITE_BLINK_EN
    localparam int   c_BLINK = 2;
    localparam logic c_HID   = 1'b0;
`else
    localparam int   c_BLINK = 30;
    localparam logic c_HID   = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [3:0] cfg_glyph = '0;
    logic [9:0] cfg_org_x = '0;
    logic [9:0] cfg_org_y = '0;
    logic [1:0] cfg_scale = '0;
    logic       blink_on = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       pix_valid = 1'b0;
    logic [5:0] pix_color;
    logic       pix_hit;
    logic       pix_out_valid;

    int total = 0;
    int bad   = 0;

    glyph_sprite_rom #(.BLINK_FRAMES(c_BLINK)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .cfg_wr(cfg_wr), .cfg_glyph(cfg_glyph), .cfg_org_x(cfg_org_x),
        .cfg_org_y(cfg_org_y), .cfg_scale(cfg_scale), .blink_on(blink_on),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .pix_color(pix_color), .pix_hit(pix_hit), .pix_out_valid(pix_out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one valid pixel, then sample its result two edges later.
    task automatic pix(input int x, input int y, input logic eh, input string tag);
        @(negedge clk);
        pix_x = x[9:0]; pix_y = y[9:0]; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".hit"}, 32'(pix_hit), 32'(eh));
        chk({tag, ".col"}, 32'(pix_color), eh ? 32'h00 : 32'h3F);
        chk({tag, ".vld"}, 32'(pix_out_valid), 32'd1);
    endtask

    task automatic cfg(input int g, input int x, input int y, input int s, input logic fs);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_glyph = g[3:0]; cfg_org_x = x[9:0]; cfg_org_y = y[9:0];
        cfg_scale = s[1:0]; frame_start = fs;
        @(negedge clk);
        cfg_wr = 1'b0; frame_start = 1'b0;
    endtask

    task automatic fstart();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vld", 32'(pix_out_valid), 32'd0);
        chk("rst.hit", 32'(pix_hit), 32'd0);
        chk("rst.col", 32'(pix_color), 32'h3F);
        @(negedge clk); reset_n = 1'b1;
        pix(1, 5, 1'b1, "rst.cfg");

        // Glyph 0 at (100,50), scale 0
        cfg(0, 100, 50, 0, 1'b0);
        fstart();
        pix(102, 51, 1'b1, "g0.top");
        pix(103, 52, 1'b0, "g0.clr");
        pix(99, 51, 1'b0, "g0.left");
        pix(108, 51, 1'b0, "g0.right");
        pix(101, 52, 1'b1, "g0.side");
        @(negedge clk);
        pix_x = 10'd102; pix_y = 10'd51; pix_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        chk("inv.hit", 32'(pix_hit), 32'd0);
        chk("inv.vld", 32'(pix_out_valid), 32'd0);

        // Scale 1 at origin
        cfg(0, 0, 0, 1, 1'b0);
        fstart();
        pix(4, 2, 1'b1, "s1.hit");
        pix(16, 0, 1'b0, "s1.out");
        pix(5, 3, 1'b1, "s1.hit2");
        pix(2, 31, 1'b0, "s1.row15");

        // Shadowed glyph change
        cfg(0, 0, 0, 0, 1'b1);
        cfg(3, 0, 0, 0, 1'b0);
        pix(1, 5, 1'b1, "sh.old1");
        pix(3, 7, 1'b0, "sh.old2");
        fstart();
        pix(1, 5, 1'b0, "sh.new1");
        pix(3, 7, 1'b1, "sh.new2");
        cfg(12, 300, 300, 2, 1'b0);
        fstart();
        pix(3, 7, 1'b1, "drop");

        // Write and frame_start together
        cfg(0, 200, 0, 0, 1'b1);
        pix(202, 1, 1'b1, "same.hit");
        pix(203, 7, 1'b0, "same.g0");

        // Right-edge clipping, no wrap
        cfg(0, 1020, 0, 0, 1'b1);
        pix(1023, 1, 1'b1, "clip.in");
        pix(0, 1, 1'b0, "clip.wrap");

        // Blinking
        @(negedge clk); blink_on = 1'b1;
        fstart(); fstart();
        pix(1023, 1, c_HID, "blk.off");
        fstart(); fstart();
        pix(1023, 1, 1'b1, "blk.on");
        fstart(); fstart();
        @(negedge clk); blink_on = 1'b0;
        pix(1023, 1, 1'b1, "blk.dis");
        fstart(); fstart();
        pix(1023, 1, 1'b1, "blk.dis2");

        // Reset with a hit in flight
        @(negedge clk);
        pix_x = 10'd1023; pix_y = 10'd1; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0; reset_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst.hit", 32'(pix_hit), 32'd0);
        chk("mrst.vld", 32'(pix_out_valid), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        pix(1023, 1, 1'b0, "mrst.cfg");
        pix(2, 1, 1'b1, "mrst.g0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
